fpu_out_sched: RTL
==================

# fpu_out_sched

Output scheduler for the FPU result path. It arbitrates between the divide, multiply and add pipes for the single CPX result request slot. Divide has top priority, add and multiply share the slot round-robin, and an optional starvation guard lets add/mul pre-empt a continuous divide stream. It sits between the pipe output stages and the CPX request (CQ) stage, and registers the winning request ID, thread and pipe onehot.

## Interface
- `ID_W`, default 10: request ID width; `[ID_W-1:2]` is the CPX request vector, `[1:0]` is the thread.
- `STARVE_MAX`, default 4: consecutive divide grants tolerated while add/mul wait (1..15).

- `rclk` input 1: clock; single clock domain.
- `rst` input 1: synchronous reset, active-high.
- `div_req` input 1: divide pipe has a result; held until `div_gnt`.
- `mul_req` input 1: multiply pipe has a result; held until `mul_gnt`.
- `add_req` input 1: add pipe has a result; held until `add_gnt`.
- `div_id` input ID_W: divide request ID; stable while `div_req`.
- `mul_id` input ID_W: multiply request ID.
- `add_id` input ID_W: add request ID.
- `cpx_stall` input 1: CPX cannot accept a request this cycle.
- `div_gnt` output 1: combinational grant to divide.
- `mul_gnt` output 1: combinational grant to multiply.
- `add_gnt` output 1: combinational grant to add.
- `fp_cpx_req_cq` output ID_W-2: registered CPX request vector.
- `req_thread` output 2: registered thread of the issued request.
- `dest_rdy` output 3: registered onehot of the winning pipe, ordered {div, mul, add}.
- `req_vld` output 1: registered; a request was issued last cycle.

## Operation
- State: `add_ptr` (1 bit, 1 = add preferred) and `starve_cnt` (4 bits, saturating).
- No grant is given while `rst` or `cpx_stall` is high.
- **Normal arbitration.** `div_req` wins. Otherwise the round-robin winner is:
  - `add` if `add_req && (add_ptr || !mul_req)`;
  - `mul` if `mul_req && (!add_ptr || !add_req)`.
- **Pre-emption.** When `starve_cnt == STARVE_MAX` and `(add_req || mul_req)`, the round-robin winner is granted instead of divide. Divide waits.
- At most one `*_gnt` is high in any cycle.
- **`add_ptr`.** Toggles on any `add_gnt` or `mul_gnt`. It is unchanged on a divide grant, a stall or an idle cycle.
- **`starve_cnt` update:**
  - clears to 0 on `add_gnt`, `mul_gnt`, or any cycle where `!(add_req || mul_req)`;
  - increments on `div_gnt && (add_req || mul_req)`, saturating at `STARVE_MAX`;
  - holds during `cpx_stall`.
- **Registered outputs, each cycle:**
  - `req_vld` = any grant;
  - `dest_rdy` = {div_gnt, mul_gnt, add_gnt};
  - `fp_cpx_req_cq` = winner `id[ID_W-1:2]`, `req_thread` = winner `id[1:0]`;
  - with no grant, the ID and thread fields are loaded with 0.
- **Requester protocol.** A requester that deasserts `req` before its grant is a protocol error and is not checked. It simply drops out of arbitration.

## Timing
- Grant is combinational in the same cycle as `req`. The requester drops or advances on the next edge.
- Request outputs are valid one cycle after the grant: latency 1.
- Back-to-back grants are allowed every cycle, including to the same pipe. Throughput is 1 per cycle.
- **Reset values:** `req_vld`=0, `dest_rdy`=3'b000, `fp_cpx_req_cq`=0, `req_thread`=0, `add_ptr`=0 (multiply preferred first), `starve_cnt`=0.
- **Reset mid-operation.** Grants are forced low in the same cycle. State and outputs are cleared at the next edge, and an in-flight registered request is discarded.
- **Stall.** `cpx_stall`=1 yields `req_vld`=0 on the next cycle. Requests stay pending, and arbitration resumes with unchanged `add_ptr` and `starve_cnt`.

## Configuration
- `FPU_OUT_STARVE_EN` defined: `starve_cnt` and the pre-emption path are present, as described above.
- Not defined: no counter is built. Divide has strict absolute priority, and add/mul are granted only in cycles without `div_req`. All other behaviour is identical.

## Test plan
- **Reset.** Assert `rst` with all reqs high → all gnts=0 → after release, `dest_rdy`=000 and `req_vld`=0.
- **Round-robin.** `add_req`=`mul_req`=1 held for 4 cycles, `div_req`=0 → grants mul, add, mul, add. `dest_rdy` follows one cycle later: 010, 001, 010, 001.
- **Divide priority.** All three reqs, `div_id`=10'h3A5, starve disabled → `div_gnt`=1, next cycle `fp_cpx_req_cq`=8'hE9, `req_thread`=2'b01, `dest_rdy`=100.
- **Starvation (macro on, `STARVE_MAX`=4).** `div_req` and `add_req` held continuously → 4 divide grants, then `add_gnt` in cycle 5, then divide again with `starve_cnt`=0. With the macro off → `add_gnt` never asserts.
- **Stall.** `mul_req`=1, `cpx_stall`=1 for 3 cycles → no gnt and `req_vld`=0 throughout. When the stall drops → `mul_gnt`=1 that cycle, and `add_ptr` toggles only then.
- **Simultaneous edge.** `add_req` rises in the same cycle `mul_gnt` fires with `add_ptr`=0 → `add_gnt` on the following cycle even though `mul_req` is still high.

Source files
------------

// File: rtl/fpu_out_sched.sv
// fpu_out_sched: picks one of the divide, multiply and add result pipes for
// the single CPX request slot and registers the winner's ID, thread and pipe
// onehot. Divide has top priority and add/mul alternate round-robin.
// Optional macro FPU_OUT_STARVE_EN adds a saturating counter. After
// STARVE_MAX consecutive divide grants taken while add or mul is waiting,
// the add/mul round-robin winner is granted ahead of divide.
module fpu_out_sched #(
  parameter int ID_W       = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic            rclk,
  input  logic            rst,
  input  logic            div_req,
  input  logic            mul_req,
  input  logic            add_req,
  input  logic [ID_W-1:0] div_id,
  input  logic [ID_W-1:0] mul_id,
  input  logic [ID_W-1:0] add_id,
  input  logic            cpx_stall,
  output logic            div_gnt,
  output logic            mul_gnt,
  output logic            add_gnt,
  output logic [ID_W-3:0] fp_cpx_req_cq,
  output logic [1:0]      req_thread,
  output logic [2:0]      dest_rdy,
  output logic            req_vld
);

  // Stop elaboration if the counter limit does not fit the 4-bit counter.
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("fpu_out_sched: STARVE_MAX must be in 1..15");
  end

  typedef struct packed {
    logic [ID_W-3:0] vec;
    logic [1:0]      thr;
  } cpx_req_t;

  logic     add_ptr_q, add_ptr_d;   // 1 = add preferred over mul
  logic     can_gnt;
  logic     rr_any, rr_add, rr_mul;
  logic     preempt;
  cpx_req_t win_d;

  assign can_gnt = !rst && !cpx_stall;
  assign rr_any  = add_req || mul_req;
  assign rr_add  = add_req && (add_ptr_q || !mul_req);
  assign rr_mul  = mul_req && (!add_ptr_q || !add_req);

`ifdef FPU_OUT_STARVE_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;

  assign preempt = (starve_q == STARVE_LIM) && rr_any;

  // Count divide grants taken while add/mul wait. A stall freezes the count.
  always_comb begin
    starve_d = starve_q;
    if (cpx_stall) begin
      starve_d = starve_q;
    end else if (!rr_any || add_gnt || mul_gnt) begin
      starve_d = '0;
    end else if (div_gnt && starve_q != STARVE_LIM) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge rclk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign preempt = 1'b0;
`endif

  // Grants. At most one is high, and none is high during reset or stall.
  assign div_gnt = can_gnt && div_req && !preempt;
  assign mul_gnt = can_gnt && rr_mul && (!div_req || preempt);
  assign add_gnt = can_gnt && rr_add && (!div_req || preempt);

  // Winner ID mux. With no grant the fields load as zero.
  always_comb begin
    win_d = '0;
    if (div_gnt)      win_d = cpx_req_t'(div_id);
    else if (mul_gnt) win_d = cpx_req_t'(mul_id);
    else if (add_gnt) win_d = cpx_req_t'(add_id);
  end

  // The pointer flips only when an add or mul actually wins the slot.
  always_comb begin
    add_ptr_d = add_ptr_q;
    if (add_gnt || mul_gnt) add_ptr_d = !add_ptr_q;
  end

  // Arbitration state and the registered CPX request.
  always_ff @(posedge rclk) begin
    if (rst) begin
      add_ptr_q     <= 1'b0;
      req_vld       <= 1'b0;
      dest_rdy      <= 3'b000;
      fp_cpx_req_cq <= '0;
      req_thread    <= 2'b00;
    end else begin
      add_ptr_q     <= add_ptr_d;
      req_vld       <= div_gnt || mul_gnt || add_gnt;
      dest_rdy      <= {div_gnt, mul_gnt, add_gnt};
      fp_cpx_req_cq <= win_d.vec;
      req_thread    <= win_d.thr;
    end
  end

endmodule
